// File: rtl/cond_logic_mt_if.sv
// Decoder-side bundle for the multi-context condition checker: instruction
// controls in, gated controls and per-context readback out.
interface cond_logic_mt_if #(
    parameter int CTX_W = 1,
    parameter int CNT_W = 16
);
    logic             valid_in;
    logic [CTX_W-1:0] ctx_in;
    logic [3:0]       cond;
    logic [3:0]       alu_flags;
    logic [1:0]       flag_w;
    logic             pcs;
    logic             reg_w;
    logic             mem_w;
    logic             no_write;
    logic [CTX_W-1:0] rd_ctx;
    logic             cnt_clr;

    logic             valid_out;
    logic             cond_ex;
    logic             pc_src;
    logic             reg_write;
    logic             mem_write;
    logic [3:0]       flags_rd;
    logic [CNT_W-1:0] exec_cnt;
    logic [CNT_W-1:0] squash_cnt;

    modport master (
        output valid_in, ctx_in, cond, alu_flags, flag_w, pcs, reg_w, mem_w,
               no_write, rd_ctx, cnt_clr,
        input  valid_out, cond_ex, pc_src, reg_write, mem_write, flags_rd,
               exec_cnt, squash_cnt
    );

    modport slave (
        input  valid_in, ctx_in, cond, alu_flags, flag_w, pcs, reg_w, mem_w,
               no_write, rd_ctx, cnt_clr,
        output valid_out, cond_ex, pc_src, reg_write, mem_write, flags_rd,
               exec_cnt, squash_cnt
    );
endinterface

// File: rtl/cond_logic_mt.sv
// Per-context NZCV flag store with ARM condition evaluation, control gating,
// saturating executed/squashed counters and an optional output register.
module cond_logic_mt #(
    parameter int NUM_CTX = 2,
    parameter int CTX_W   = 1,
    parameter int CNT_W   = 16,
    parameter int REG_OUT = 0
) (
    input  logic          clk,
    input  logic          reset,
    cond_logic_mt_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]       flags_q  [NUM_CTX];
    logic [CNT_W-1:0] exec_q   [NUM_CTX];
    logic [CNT_W-1:0] squash_q [NUM_CTX];

    logic [CTX_W-1:0]   ctx_idx;
    logic [CTX_W-1:0]   rd_idx;
    logic [NUM_CTX-1:0] ctx_sel;
    logic [NUM_CTX-1:0] rd_sel;
    logic [3:0]         cur_flags;
    logic               ctx_ok;
    logic               n, z, c, v, ge;
    logic               dec;
    logic               term;
    logic               valid_c, pc_c, rw_c, mw_c;

    assign ctx_idx = bus.ctx_in;
    assign rd_idx  = bus.rd_ctx;

    // One-hot context matches; an index past NUM_CTX matches nothing.
    always_comb begin
        ctx_sel = '0;
        rd_sel  = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            ctx_sel[i] = (32'(ctx_idx) == 32'(i));
            rd_sel[i]  = (32'(rd_idx) == 32'(i));
        end
    end

    assign ctx_ok = |ctx_sel;

    always_comb begin
        cur_flags      = 4'b0000;
        bus.flags_rd   = 4'b0000;
        bus.exec_cnt   = '0;
        bus.squash_cnt = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (ctx_sel[i]) cur_flags = flags_q[i];
            if (rd_sel[i]) begin
                bus.flags_rd   = flags_q[i];
                bus.exec_cnt   = exec_q[i];
                bus.squash_cnt = squash_q[i];
            end
        end
    end

    assign {n, z, c, v} = cur_flags;
    assign ge = ~(n ^ v);

    always_comb begin
        case (bus.cond)
            4'b0000: dec = z;
            4'b0001: dec = ~z;
            4'b0010: dec = c;
            4'b0011: dec = ~c;
            4'b0100: dec = n;
            4'b0101: dec = ~n;
            4'b0110: dec = v;
            4'b0111: dec = ~v;
            4'b1000: dec = c & ~z;
            4'b1001: dec = ~(c & ~z);
            4'b1010: dec = ge;
            4'b1011: dec = ~ge;
            4'b1100: dec = ~z & ge;
            4'b1101: dec = ~(~z & ge);
            4'b1110: dec = 1'b1;
            default: dec = 1'b0;
        endcase
    end

    assign term    = bus.valid_in & ctx_ok & dec;
    assign valid_c = bus.valid_in;
    assign pc_c    = term & bus.pcs;
    assign rw_c    = term & bus.reg_w & ~bus.no_write;
    assign mw_c    = term & bus.mem_w;

    // Flags and counters update at the end of the input cycle; readback above
    // therefore never sees the value being written on this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                flags_q[i]  <= 4'b0000;
                exec_q[i]   <= '0;
                squash_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CTX; i++) begin
                if (term && ctx_sel[i]) begin
                    if (bus.flag_w[1]) flags_q[i][3:2] <= bus.alu_flags[3:2];
                    if (bus.flag_w[0]) flags_q[i][1:0] <= bus.alu_flags[1:0];
                end
                if (bus.cnt_clr) begin
                    exec_q[i]   <= '0;
                    squash_q[i] <= '0;
                end else if (bus.valid_in && ctx_sel[i]) begin
                    if (term) begin
                        if (exec_q[i] != CNT_MAX) exec_q[i] <= exec_q[i] + CNT_W'(1);
                    end else begin
                        if (squash_q[i] != CNT_MAX) squash_q[i] <= squash_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            always_ff @(posedge clk) begin
                if (reset) begin
                    bus.valid_out <= 1'b0;
                    bus.cond_ex   <= 1'b0;
                    bus.pc_src    <= 1'b0;
                    bus.reg_write <= 1'b0;
                    bus.mem_write <= 1'b0;
                end else begin
                    bus.valid_out <= valid_c;
                    bus.cond_ex   <= term;
                    bus.pc_src    <= pc_c;
                    bus.reg_write <= rw_c;
                    bus.mem_write <= mw_c;
                end
            end
        end else begin : g_comb_out
            always_comb begin
                bus.valid_out = valid_c;
                bus.cond_ex   = term;
                bus.pc_src    = pc_c;
                bus.reg_write = rw_c;
                bus.mem_write = mw_c;
            end
        end
    endgenerate

endmodule

// File: tb/tb_cond_logic_mt.sv
// Bench for cond_logic_mt: a combinational and a registered-output instance
// share one stimulus stream and one behavioural model of the flag/counter state.
module tb_cond_logic_mt;

    localparam int NCTX  = 3;
    localparam int CW    = 2;
    localparam int NW    = 4;
    localparam int CMAX  = 15;

    logic clk = 1'b0;
    logic reset;
    logic          valid_in;
    logic [CW-1:0] ctx_in;
    logic [3:0]    cond;
    logic [3:0]    alu_flags;
    logic [1:0]    flag_w;
    logic          pcs, reg_w, mem_w, no_write;
    logic [CW-1:0] rd_ctx;
    logic          cnt_clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cond_logic_mt_if #(.CTX_W(CW), .CNT_W(NW)) if_c ();
    cond_logic_mt_if #(.CTX_W(CW), .CNT_W(NW)) if_r ();

    assign if_c.valid_in = valid_in;   assign if_r.valid_in = valid_in;
    assign if_c.ctx_in = ctx_in;       assign if_r.ctx_in = ctx_in;
    assign if_c.cond = cond;           assign if_r.cond = cond;
    assign if_c.alu_flags = alu_flags; assign if_r.alu_flags = alu_flags;
    assign if_c.flag_w = flag_w;       assign if_r.flag_w = flag_w;
    assign if_c.pcs = pcs;             assign if_r.pcs = pcs;
    assign if_c.reg_w = reg_w;         assign if_r.reg_w = reg_w;
    assign if_c.mem_w = mem_w;         assign if_r.mem_w = mem_w;
    assign if_c.no_write = no_write;   assign if_r.no_write = no_write;
    assign if_c.rd_ctx = rd_ctx;       assign if_r.rd_ctx = rd_ctx;
    assign if_c.cnt_clr = cnt_clr;     assign if_r.cnt_clr = cnt_clr;

    cond_logic_mt #(.NUM_CTX(NCTX), .CTX_W(CW), .CNT_W(NW), .REG_OUT(0)) u_comb (
        .clk(clk), .reset(reset), .bus(if_c)
    );
    cond_logic_mt #(.NUM_CTX(NCTX), .CTX_W(CW), .CNT_W(NW), .REG_OUT(1)) u_reg (
        .clk(clk), .reset(reset), .bus(if_r)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic v, ce, pc, rw, mw;
    } outs_t;

    logic [3:0] m_flags [NCTX];
    int         m_exec  [NCTX];
    int         m_squash[NCTX];
    outs_t      m_prev;
    bit         started = 1'b0;

    // Conditions come in pairs: even code tests a predicate, odd code is its inverse.
    function automatic bit m_pass(input logic [3:0] f, input logic [3:0] cd);
        bit nn = f[3], zz = f[2], cc = f[1], vv = f[0];
        bit base;
        case (cd[3:1])
            3'd0: base = zz;
            3'd1: base = cc;
            3'd2: base = nn;
            3'd3: base = vv;
            3'd4: base = cc && !zz;
            3'd5: base = (nn == vv);
            3'd6: base = !zz && (nn == vv);
            default: return (cd[0] == 1'b0);
        endcase
        return cd[0] ? !base : base;
    endfunction

    function automatic bit m_term();
        if (valid_in !== 1'b1 || int'(ctx_in) >= NCTX) return 1'b0;
        return m_pass(m_flags[ctx_in], cond);
    endfunction

    function automatic outs_t m_outs();
        outs_t o;
        bit t = m_term();
        o.v  = valid_in;
        o.ce = t;
        o.pc = t && pcs;
        o.rw = t && reg_w && !no_write;
        o.mw = t && mem_w;
        return o;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            started <= 1'b1;
            m_prev  <= '0;
            for (int i = 0; i < NCTX; i++) begin
                m_flags[i]  <= 4'b0000;
                m_exec[i]   <= 0;
                m_squash[i] <= 0;
            end
        end else begin
            m_prev <= m_outs();
            if (m_term()) begin
                m_flags[ctx_in] <= {flag_w[1] ? alu_flags[3:2] : m_flags[ctx_in][3:2],
                                    flag_w[0] ? alu_flags[1:0] : m_flags[ctx_in][1:0]};
            end
            for (int i = 0; i < NCTX; i++) begin
                if (cnt_clr) begin
                    m_exec[i]   <= 0;
                    m_squash[i] <= 0;
                end else if (valid_in && int'(ctx_in) == i) begin
                    if (m_term()) m_exec[i] <= (m_exec[i] >= CMAX) ? CMAX : m_exec[i] + 1;
                    else          m_squash[i] <= (m_squash[i] >= CMAX) ? CMAX : m_squash[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("comb.valid_out", 32'(if_c.valid_out), 32'(m_outs().v));
            chk("comb.cond_ex",   32'(if_c.cond_ex),   32'(m_outs().ce));
            chk("comb.pc_src",    32'(if_c.pc_src),    32'(m_outs().pc));
            chk("comb.reg_write", 32'(if_c.reg_write), 32'(m_outs().rw));
            chk("comb.mem_write", 32'(if_c.mem_write), 32'(m_outs().mw));
            chk("reg.valid_out",  32'(if_r.valid_out), 32'(m_prev.v));
            chk("reg.cond_ex",    32'(if_r.cond_ex),   32'(m_prev.ce));
            chk("reg.pc_src",     32'(if_r.pc_src),    32'(m_prev.pc));
            chk("reg.reg_write",  32'(if_r.reg_write), 32'(m_prev.rw));
            chk("reg.mem_write",  32'(if_r.mem_write), 32'(m_prev.mw));
            if (int'(rd_ctx) < NCTX) begin
                chk("comb.flags_rd",   32'(if_c.flags_rd),   32'(m_flags[rd_ctx]));
                chk("comb.exec_cnt",   32'(if_c.exec_cnt),   32'(m_exec[rd_ctx]));
                chk("comb.squash_cnt", 32'(if_c.squash_cnt), 32'(m_squash[rd_ctx]));
                chk("reg.flags_rd",    32'(if_r.flags_rd),   32'(m_flags[rd_ctx]));
                chk("reg.exec_cnt",    32'(if_r.exec_cnt),   32'(m_exec[rd_ctx]));
            end else begin
                chk("comb.flags_rd_oor", 32'(if_c.flags_rd),   32'(0));
                chk("comb.exec_oor",     32'(if_c.exec_cnt),   32'(0));
                chk("comb.squash_oor",   32'(if_c.squash_cnt), 32'(0));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [CW-1:0] cx, input logic [3:0] cd,
                         input logic [3:0] af, input logic [1:0] fw);
        valid_in = 1'b1; ctx_in = cx; cond = cd; alu_flags = af; flag_w = fw;
        pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
    endtask

    task automatic idle();
        valid_in = 1'b0; flag_w = 2'b00; pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cnt_clr = 1'b0; rd_ctx = '0;
        instr(2'd0, 4'b1110, 4'b0000, 2'b00);
        idle();
        tick(); tick();
        reset = 1'b0;
        #2;
        chk("lit.reset_flags", 32'(if_c.flags_rd), 32'h0);
        chk("lit.reset_exec", 32'(if_c.exec_cnt), 32'h0);
        chk("lit.reset_regout", 32'(if_r.valid_out), 32'h0);

        // EQ with Z=0 fails, then load Z and EQ passes
        instr(2'd0, 4'b0000, 4'b0000, 2'b00); #2;
        chk("lit.eq_z0", 32'(if_c.cond_ex), 32'h0);
        tick();
        instr(2'd0, 4'b1110, 4'b0100, 2'b10); tick();
        chk("lit.flags_0100", 32'(if_c.flags_rd), 32'h4);
        instr(2'd0, 4'b0000, 4'b0000, 2'b00); #2;
        chk("lit.eq_z1", 32'(if_c.cond_ex), 32'h1);
        tick();

        // context isolation
        instr(2'd0, 4'b1110, 4'b1000, 2'b11); tick();
        instr(2'd1, 4'b1110, 4'b0001, 2'b11); tick();
        instr(2'd0, 4'b1010, 4'b0000, 2'b00); #2;
        chk("lit.ge_ctx0", 32'(if_c.cond_ex), 32'h0);
        tick();
        instr(2'd1, 4'b1010, 4'b0000, 2'b00); #2;
        chk("lit.ge_ctx1", 32'(if_c.cond_ex), 32'h0);
        tick();
        instr(2'd1, 4'b1110, 4'b1001, 2'b11); tick();
        instr(2'd1, 4'b1010, 4'b0000, 2'b00); #2;
        chk("lit.ge_ctx1_pass", 32'(if_c.cond_ex), 32'h1);
        tick();
        idle(); #2;
        chk("lit.ctx0_hold", 32'(if_c.flags_rd), 32'h8);
        tick();

        // gating
        instr(2'd0, 4'b1110, 4'b0100, 2'b11); tick();
        instr(2'd0, 4'b0001, 4'b0000, 2'b00); pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1; #2;
        chk("lit.ne_pc", 32'(if_c.pc_src), 32'h0);
        chk("lit.ne_rw", 32'(if_c.reg_write), 32'h0);
        chk("lit.ne_mw", 32'(if_c.mem_write), 32'h0);
        tick();
        instr(2'd0, 4'b0000, 4'b0000, 2'b00); pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
        no_write = 1'b1; #2;
        chk("lit.nowrite_rw", 32'(if_c.reg_write), 32'h0);
        chk("lit.nowrite_mw", 32'(if_c.mem_write), 32'h1);
        tick();

        // back-to-back on one context, and a failing cond does not write
        instr(2'd0, 4'b1110, 4'b0000, 2'b10); tick();
        instr(2'd0, 4'b0001, 4'b0000, 2'b00); #2;
        chk("lit.b2b_ne", 32'(if_c.cond_ex), 32'h1);
        tick();
        instr(2'd0, 4'b0000, 4'b0100, 2'b10); #2;
        chk("lit.nobypass", 32'(if_c.cond_ex), 32'h0);
        tick();
        idle(); #2;
        chk("lit.nobypass_flags", 32'(if_c.flags_rd), 32'h0);

        // squashed write and half write
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        instr(2'd0, 4'b1111, 4'b1111, 2'b11); tick();
        idle(); #2;
        chk("lit.nv_flags", 32'(if_c.flags_rd), 32'h0);
        chk("lit.nv_squash", 32'(if_c.squash_cnt), 32'h1);
        instr(2'd0, 4'b1110, 4'b0100, 2'b11); tick();
        instr(2'd0, 4'b1110, 4'b0011, 2'b01); tick();
        idle(); #2;
        chk("lit.half_write", 32'(if_c.flags_rd), 32'h7);

        // saturation, then clear colliding with an increment
        for (int k = 0; k < 20; k++) begin
            instr(2'd0, 4'b1110, 4'b0000, 2'b00); tick();
        end
        idle(); #2;
        chk("lit.sat_exec", 32'(if_c.exec_cnt), 32'd15);
        instr(2'd0, 4'b1110, 4'b0000, 2'b00); cnt_clr = 1'b1; tick();
        cnt_clr = 1'b0; idle(); #2;
        chk("lit.clr_wins", 32'(if_c.exec_cnt), 32'h0);

        // out-of-range context and readback
        instr(2'd3, 4'b1110, 4'b1111, 2'b11); #2;
        chk("lit.oor_cond", 32'(if_c.cond_ex), 32'h0);
        tick();
        idle(); rd_ctx = 2'd3; #2;
        chk("lit.oor_rd", 32'(if_c.flags_rd), 32'h0);
        rd_ctx = 2'd0; #1;
        chk("lit.oor_nocount", 32'(if_c.squash_cnt), 32'h0);
        tick();
        instr(2'd2, 4'b1110, 4'b1010, 2'b11); rd_ctx = 2'd2; tick();
        idle(); #2;
        chk("lit.ctx2_flags", 32'(if_c.flags_rd), 32'ha);
        tick();

        // registered stage lags by one cycle
        instr(2'd1, 4'b1110, 4'b0000, 2'b00); pcs = 1'b1; #2;
        chk("lit.reg_before", 32'(if_r.cond_ex), 32'h0);
        tick();
        idle(); #2;
        chk("lit.reg_after", 32'(if_r.pc_src), 32'h1);
        chk("lit.comb_after", 32'(if_c.pc_src), 32'h0);
        tick();

        // sweep every cond code on ctx1 with varying flags and controls
        for (int k = 0; k < 16; k++) begin
            instr(2'd1, 4'(k), 4'(k * 5), 2'(k));
            pcs = k[0]; reg_w = k[1]; mem_w = k[2]; no_write = k[3];
            rd_ctx = 2'(k % 4);
            tick();
        end

        // reset in the middle of a sequence
        rd_ctx = 2'd2;
        instr(2'd1, 4'b1110, 4'b0000, 2'b00); tick();
        instr(2'd2, 4'b1110, 4'b1111, 2'b11); reset = 1'b1; tick();
        reset = 1'b0; idle(); #2;
        chk("lit.rst_regout", 32'(if_r.valid_out), 32'h0);
        chk("lit.rst_flags", 32'(if_c.flags_rd), 32'h0);
        chk("lit.rst_exec", 32'(if_c.exec_cnt), 32'h0);
        tick();
        instr(2'd2, 4'b0101, 4'b0000, 2'b00); tick();
        idle(); tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cond_logic_mt.md
Name: cond_logic_mt

Overview:
Parametrised successor to the single-context condition checker. Holds one NZCV flag register per hardware context and evaluates the 4-bit ARM condition field against the flags of the selected context. It gates the PCSrc, RegWrite and MemWrite controls and updates flags conditionally. It keeps saturating executed/squashed counters per context and can add a registered output stage. It sits between the decoder and the writeback/fetch control in the datapath.

Parameters:
NUM_CTX, 2, number of independent flag contexts (≥1)
CTX_W, 1, context index width (≥1; must satisfy 2**CTX_W ≥ NUM_CTX)
CNT_W, 16, width of each per-context counter
REG_OUT, 0, 0 = combinational gated outputs; 1 = one register stage on all outputs

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
valid_in  in  1  instruction present this cycle
ctx_in  in  CTX_W  context of the instruction
cond  in  4  condition code
alu_flags  in  4  {N,Z,C,V} from the ALU
flag_w  in  2  bit1 = write N,Z; bit0 = write C,V
pcs  in  1  ungated PCSrc
reg_w  in  1  ungated RegWrite
mem_w  in  1  ungated MemWrite
no_write  in  1  compare-type instruction; suppresses RegWrite
rd_ctx  in  CTX_W  context selected for the counter/flag readback
cnt_clr  in  1  clear all counters
valid_out  out  1  outputs are valid
cond_ex  out  1  condition passed
pc_src  out  1  gated PCSrc
reg_write  out  1  gated RegWrite
mem_write  out  1  gated MemWrite
flags_rd  out  4  flag register of rd_ctx, {N,Z,C,V}
exec_cnt  out  CNT_W  executed count for rd_ctx
squash_cnt  out  CNT_W  squashed count for rd_ctx

Behaviour:
- Reset (synchronous, active-high):
  - All flag registers = 4'b0000.
  - All counters = 0.
  - If REG_OUT=1, valid_out, cond_ex, pc_src, reg_write and mem_write = 0.
- Condition decode uses the flags of ctx_in at the start of the cycle, with ge = (N==V):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~(C&~Z)
  - 1010 GE: ge
  - 1011 LT: ~ge
  - 1100 GT: ~Z&ge
  - 1101 LE: ~(~Z&ge)
  - 1110 AL: 1
  - 1111: 0 (invalid; never executes)
- Internal condition-passed term = valid_in & decode. This term gates all controls:
  - pc_src = term & pcs
  - reg_write = term & reg_w & ~no_write
  - mem_write = term & mem_w
- Flag update, at the clock edge, applies only to flags[ctx_in] and only when the term is 1:
  - flag_w[1]=1 loads N,Z from alu_flags[3:2].
  - flag_w[0]=1 loads C,V from alu_flags[1:0].
  - Unwritten halves hold.
  - Other contexts never change.
- Flag timing:
  - The new flags are visible from the next cycle. Back-to-back instructions on the same context see the updated flags with no stall.
  - There is no same-cycle bypass: the evaluation in cycle t uses the flags as they stood before the edge at the end of cycle t.
- Counters, when valid_in=1:
  - exec_cnt[ctx_in] += 1 if the condition passes; otherwise squash_cnt[ctx_in] += 1.
  - Both saturate at 2**CNT_W-1; there is no wrap.
  - cnt_clr=1 zeroes every counter. If a clear and an increment occur in the same cycle, the clear wins and the result is 0.
- Readback:
  - flags_rd, exec_cnt and squash_cnt are combinational reads of the rd_ctx entry. They show the registered value, not the value being written this edge.
  - rd_ctx ≥ NUM_CTX reads 0.
- Out-of-range context: ctx_in ≥ NUM_CTX forces decode = 0 (squashed), causes no flag write and increments no counter.
- Output latency:
  - REG_OUT=0: the outputs are combinational from the inputs, with valid_out = valid_in and cond_ex = term.
  - REG_OUT=1: the same values are registered, so latency is 1 cycle. The flag update still happens at the end of the input cycle. Readback is unaffected by REG_OUT.
- valid_in=0 forces cond_ex=0 and all gated outputs to 0.

Test Plan:
- Reset, then cond=0000, valid_in=1, ctx 0 → cond_ex=0 (Z=0). Next: alu_flags=0100, flag_w=10, cond=1110 → flags_rd(ctx0)=0100 the next cycle. Then cond=0000 → cond_ex=1.
- Context isolation: set ctx0 flags to 1000 and ctx1 flags to 0001. cond=1010 on ctx0 → 0; on ctx1 → 0. Set ctx1 to 1001, then GE on ctx1 → 1, and ctx0 flags remain 1000.
- Gating: cond=0001 with Z=1, pcs=reg_w=mem_w=1 → pc_src=reg_write=mem_write=0. Also a passing cond with no_write=1, reg_w=1 → reg_write=0.
- Squashed flag write:
  - cond=1111 with flag_w=11, alu_flags=1111 → flags unchanged, and squash_cnt increments by 1.
  - Half write: flag_w=01 from 0100 with alu_flags=0011 → 0111.
- Counter saturation with CNT_W=4: 20 AL instructions on ctx0 → exec_cnt=15. Then cnt_clr asserted together with a valid AL instruction → exec_cnt=0 the next cycle.
- REG_OUT=1: the outputs lag the inputs by exactly 1 cycle. A synchronous reset pulse in the middle of a sequence → the next-cycle outputs, flags and counters are 0.
